// File: rtl/ans_decoder_pkg.sv
// Shared constants, state type and magnitude helper for the ans_decoder display path.
package ans_decoder_pkg;

   localparam logic [15:0] DISP_MAX   = 16'd9999;
   localparam int          BCD_DIGITS = 4;
   localparam logic [3:0]  CONV_ITERS = 4'd14;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } ans_dec_state_t;

   // Absolute value of a two's-complement word, clamped to what four digits can show.
   function automatic logic [13:0] sat_mag(input logic [15:0] v);
      logic [15:0] m;
      m = v[15] ? (~v + 16'd1) : v;
      if (m > DISP_MAX) begin
         return DISP_MAX[13:0];
      end else begin
         return m[13:0];
      end
   endfunction

endpackage

// File: rtl/ans_decoder_bcd_shift_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left taking bit_in.
module bcd_shift_step
   import ans_decoder_pkg::*;
(
   input  logic [15:0] bcd,
   input  logic        bit_in,
   output logic [15:0] bcd_next
);

   logic [14:0] adj_s;

   genvar i;
   for (i = 0; i < BCD_DIGITS - 1; i++) begin : g_nib
      assign adj_s[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? (bcd[4*i +: 4] + 4'd3) : bcd[4*i +: 4];
   end

   // The top nibble's carry-out is shifted away, so only its low three bits are kept.
   assign adj_s[14:12] = (bcd[15:12] >= 4'd5) ? (bcd[14:12] + 3'd3) : bcd[14:12];

   assign bcd_next = {adj_s, bit_in};

endmodule

// File: rtl/ans_decoder.sv
// Sequential 16-bit two's-complement to sign + 4-digit BCD converter, one result per 16-cycle frame.
module ans_decoder
   import ans_decoder_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ans,
   output logic        sign,
   output logic [3:0]  num1,
   output logic [3:0]  num2,
   output logic [3:0]  num3,
   output logic [3:0]  num4
);

   ans_dec_state_t state_r;
   ans_dec_state_t state_next_s;
   logic [3:0]     cnt_r;
   logic [13:0]    mag_r;
   logic [15:0]    bcd_r;
   logic [15:0]    bcd_step_s;
   logic           sign_work_r;

   bcd_shift_step u_step (
      .bcd      (bcd_r),
      .bit_in   (mag_r[13]),
      .bcd_next (bcd_step_s)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= LOAD;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         LOAD:  state_next_s = SHIFT;
         SHIFT: begin
            if (cnt_r == CONV_ITERS - 4'd1) begin
               state_next_s = DONE;
            end else begin
               state_next_s = SHIFT;
            end
         end
         DONE:    state_next_s = LOAD;
         default: state_next_s = LOAD;
      endcase
   end

   // Conversion datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r       <= 4'd0;
         mag_r       <= 14'd0;
         bcd_r       <= 16'd0;
         sign_work_r <= 1'b0;
         sign        <= 1'b0;
         num1        <= 4'd0;
         num2        <= 4'd0;
         num3        <= 4'd0;
         num4        <= 4'd0;
      end else begin
         case (state_r)
            LOAD: begin
               sign_work_r <= ans[15];
               mag_r       <= sat_mag(ans);
               bcd_r       <= 16'd0;
               cnt_r       <= 4'd0;
            end
            SHIFT: begin
               bcd_r <= bcd_step_s;
               mag_r <= {mag_r[12:0], 1'b0};
               cnt_r <= cnt_r + 4'd1;
            end
            DONE: begin
               sign <= sign_work_r;
               num1 <= bcd_r[15:12];
               num2 <= bcd_r[11:8];
               num3 <= bcd_r[7:4];
               num4 <= bcd_r[3:0];
            end
            default: begin
               cnt_r <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ans_decoder.sv
// Self-checking bench for ans_decoder: frame-aligned scoreboard plus per-scenario checks.
module tb_ans_decoder;

   logic        clk;
   logic        rst;
   logic [15:0] ans;
   logic        sign;
   logic [3:0]  num1, num2, num3, num4;
   logic [16:0] obs;

   int checks = 0;
   int errors = 0;
   int k = 0;
   bit running = 1'b0;
   logic [16:0] exp_q[$];
   logic [16:0] cur_exp = 17'h0;

   ans_decoder dut (
      .clk  (clk),
      .rst  (rst),
      .ans  (ans),
      .sign (sign),
      .num1 (num1),
      .num2 (num2),
      .num3 (num3),
      .num4 (num4)
   );

   assign obs = {sign, num1, num2, num3, num4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: signed arithmetic and decimal division
   function automatic logic [16:0] model(input logic [15:0] a);
      int v;
      int m;
      v = int'($signed(a));
      m = (v < 0) ? -v : v;
      if (m > 9999) m = 9999;
      return {a[15], 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   // Scoreboard: push at LOAD edges, pop at DONE edges, require stable outputs in between
   always @(posedge clk) begin
      int phase;
      if (running) begin
         phase = k % 16;
         k = k + 1;
         if (phase == 0) exp_q.push_back(model(ans));
         #1;
         if (phase == 15) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_empty: no expected value queued at cycle %0d", k);
            end else begin
               cur_exp = exp_q.pop_front();
            end
         end
         checks++;
         if (obs !== cur_exp) begin
            errors++;
            $display("FAIL scoreboard: cycle %0d phase %0d got %h expected %h", k, phase, obs, cur_exp);
         end
      end
   end

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      running = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ans = 16'd255;
      repeat (3) @(negedge clk);
      checks++;
      if (obs !== 17'h0) begin
         errors++;
         $display("FAIL reset_initial: got %h expected %h", obs, 17'h0);
      end
      release_reset();
      repeat (40) @(negedge clk);
      checks++;
      if (obs !== {1'b0, 16'h0255}) begin
         errors++;
         $display("FAIL reset_preload: got %h expected %h", obs, {1'b0, 16'h0255});
      end
      // Mid-frame asynchronous reset
      repeat (5) @(negedge clk);
      #2;
      running = 1'b0;
      exp_q.delete();
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== 17'h0) begin
         errors++;
         $display("FAIL reset_async: got %h expected %h", obs, 17'h0);
      end
      cur_exp = 17'h0;
      release_reset();
      repeat (40) @(negedge clk);
      checks++;
      if (obs !== {1'b0, 16'h0255}) begin
         errors++;
         $display("FAIL reset_restart: got %h expected %h", obs, {1'b0, 16'h0255});
      end
   endtask

   task automatic test_values();
      logic [15:0] a_t[4] = '{16'd0, 16'd255, 16'hFFFF, 16'd387};
      logic [16:0] e_t[4] = '{17'h0_0000, {1'b0, 16'h0255}, {1'b1, 16'h0001}, {1'b0, 16'h0387}};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ans = a_t[i];
         repeat (40) @(negedge clk);
         checks++;
         if (obs !== e_t[i]) begin
            errors++;
            $display("FAIL values[%0d]: ans=%0d got %h expected %h", i, a_t[i], obs, e_t[i]);
         end
      end
   endtask

   task automatic test_saturation();
      logic [15:0] a_t[2] = '{16'd12345, 16'd32768};
      logic [16:0] e_t[2] = '{{1'b0, 16'h9999}, {1'b1, 16'h9999}};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         ans = a_t[i];
         repeat (40) @(negedge clk);
         checks++;
         if (obs !== e_t[i]) begin
            errors++;
            $display("FAIL saturation[%0d]: ans=%0d got %h expected %h", i, a_t[i], obs, e_t[i]);
         end
      end
   endtask

   task automatic test_boundary();
      logic [15:0] a_t[4] = '{16'd9999, 16'd10000, 16'd55537, 16'd55538};
      logic [16:0] e_t[4] = '{{1'b0, 16'h9999}, {1'b0, 16'h9999}, {1'b1, 16'h9999}, {1'b1, 16'h9998}};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ans = a_t[i];
         repeat (40) @(negedge clk);
         checks++;
         if (obs !== e_t[i]) begin
            errors++;
            $display("FAIL boundary[%0d]: ans=%0d got %h expected %h", i, a_t[i], obs, e_t[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      ans = 16'd4321;
      repeat (48) @(negedge clk);
      checks++;
      if (obs !== {1'b0, 16'h4321}) begin
         errors++;
         $display("FAIL back_to_back: got %h expected %h", obs, {1'b0, 16'h4321});
      end
   endtask

   task automatic test_latency();
      bit found;
      logic [16:0] e;
      @(negedge clk);
      ans = 16'd255;
      repeat (40) @(negedge clk);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if ((k % 16) == 1) found = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL latency_sync: frame start not found, got k=%0d expected k mod 16 = 1", k);
      end else begin
         ans = 16'd387;
         for (int n = 1; n <= 31; n++) begin
            @(posedge clk);
            #1;
            e = (n < 31) ? {1'b0, 16'h0255} : {1'b0, 16'h0387};
            checks++;
            if (obs !== e) begin
               errors++;
               $display("FAIL latency: cycle %0d after change got %h expected %h", n, obs, e);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      ans = 16'd0;
      test_reset();
      test_values();
      test_saturation();
      test_boundary();
      test_back_to_back();
      test_latency();
      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
